ps2_mouse_packet_assembler: RTL and testbench
=============================================

// Module: ps2_mouse_packet_assembler
// PURPOSE
//  Downstream of the PS/2 mouse receiver. Consumes its byte stream (dataout / rx_done) while the mouse
//  is in stream mode. Frames 3-byte PS/2 movement packets and publishes buttons and signed deltas.
//  Maintains a saturated on-screen cursor position for the display/UI logic.
// PARAMETERS
//  TIMEOUT_CYCLES  100000  max CLK cycles between bytes of one packet (2 ms @ 50 MHz) before resync
//  POS_W           10      width of pos_x / pos_y
//  X_MAX           639     max cursor X (inclusive); X range 0..X_MAX
//  Y_MAX           479     max cursor Y (inclusive); Y range 0..Y_MAX
// PORTS
//  CLK        in   1      system clock, all logic on rising edge
//  RST        in   1      asynchronous reset, active-low
//  rx_data    in   8      received byte from mouse receiver (its dataout)
//  rx_done    in   1      1-cycle strobe: rx_data valid this cycle
//  stream_en  in   1      receiver STREAM flag; 0 = mouse not in stream mode
//  pkt_valid  out  1      1-cycle strobe: new packet on btn_*/dx/dy/ovf, pos updated
//  btn_l/btn_r/btn_m out 1 each  button states from byte0 bits 0/1/2
//  dx         out  9      signed X delta {byte0[4], byte1}
//  dy         out  9      signed Y delta {byte0[5], byte2}, PS/2 convention (+ = up)
//  x_ovf      out  1      byte0[6]
//  y_ovf      out  1      byte0[7]
//  pos_x      out  POS_W  cursor X
//  pos_y      out  POS_W  cursor Y (screen convention, + = down)
//  sync_err   out  1      1-cycle strobe: bad header byte or inter-byte timeout
//  busy       out  1      1 while a packet is partially received (state != S_B0)
// BEHAVIOUR
//  Reset (RST=0): state S_B0, timer 0, all strobes 0, btn_*/dx/dy/ovf 0, pos_x=(X_MAX+1)/2, pos_y=(Y_MAX+1)/2.
//  FSM: S_B0 (await header) -> S_B1 -> S_B2 -> S_B0; advances only on rx_done=1 cycles.
//   S_B0: byte with rx_data[3]=1 latched as byte0 -> S_B1; rx_data[3]=0 -> dropped, sync_err=1 next cycle, stay.
//   S_B1: latch byte1 -> S_B2. S_B2: latch byte2 -> S_B0, publish.
//  Publish: cycle after byte2 rx_done, pkt_valid=1 for exactly 1 cycle; btn_*, dx, dy, ovf and pos_*
//   all show new values in that same cycle and hold until next publish.
//  Position: sign-extend dx/dy to POS_W+2 bits; nx=pos_x+dx, ny=pos_y-dy; clamp each to [0,MAX].
//   If x_ovf=1, X delta treated as 0 for pos (dx output still raw); likewise y_ovf for Y.
//  Timeout: timer clears on every accepted byte; counts in S_B1/S_B2 only. When it reaches TIMEOUT_CYCLES
//   -> S_B0, partial packet discarded, sync_err 1 cycle, no pkt_valid.
//   rx_done in the same cycle as expiry: byte wins (accepted, timer cleared).
//  stream_en=0: FSM forced to S_B0, timer cleared, rx_done ignored, no sync_err; outputs/pos hold.
//  sync_err and pkt_valid are never asserted in the same cycle.
//  RST asserted mid-packet: everything returns to reset values immediately; partial packet lost.
// TESTING
//  1. Reset, stream_en=1, bytes 0x29,0x05,0xFE -> one pkt_valid; btn_l=1, dx=+5, dy=-2, pos_x=325, pos_y=242.
//  2. In S_B0 send 0x00 then 0x08,0x01,0x01 -> sync_err pulse on 0x00; then pkt_valid, dx=+1, dy=+1, pos=(321,239).
//  3. From reset send 0x18,0x00,0x00 twice -> dx=-256 each; pos_x 320->64->0 (clamped), pos_y stays 240.
//  4. Send 0x48,0x7F,0x00 -> x_ovf=1, dx=+127, pkt_valid=1, pos_x unchanged at 320.
//  5. Send 0x08,0x01, idle TIMEOUT_CYCLES+2 -> sync_err, busy=0, no pkt_valid; next 0x09,0x02,0x00 -> btn_l=1, dx=+2.
//  6. Send 0x08,0x01, pull RST low 1 cycle, then 0x01 -> 0x01 rejected as header (sync_err), pos at reset centre.

Source files
------------

// File: rtl/ps2_mouse_packet_assembler.sv
// rtl/ps2_mouse_packet_assembler.sv - frames 3-byte PS/2 mouse packets and tracks a clamped cursor
module ps2_mouse_packet_assembler #(
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int POS_W          = 10,
    parameter int X_MAX          = 639,
    parameter int Y_MAX          = 479
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [7:0]       rx_data,
    input  logic             rx_done,
    input  logic             stream_en,
    output logic             pkt_valid,
    output logic             btn_l,
    output logic             btn_r,
    output logic             btn_m,
    output logic [8:0]       dx,
    output logic [8:0]       dy,
    output logic             x_ovf,
    output logic             y_ovf,
    output logic [POS_W-1:0] pos_x,
    output logic [POS_W-1:0] pos_y,
    output logic             sync_err,
    output logic             busy
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int PW = POS_W + 2;
    localparam logic [TW-1:0]        T_LAST  = TW'(TIMEOUT_CYCLES);
    localparam logic signed [PW-1:0] X_MAX_S = PW'(X_MAX);
    localparam logic signed [PW-1:0] Y_MAX_S = PW'(Y_MAX);
    localparam logic [POS_W-1:0]     X_CTR   = POS_W'((X_MAX + 1) / 2);
    localparam logic [POS_W-1:0]     Y_CTR   = POS_W'((Y_MAX + 1) / 2);

    typedef enum logic [1:0] {S_B0, S_B1, S_B2} state_t;

    state_t            state_q, state_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic [7:0]        byte0_q, byte0_d;
    logic [7:0]        byte1_q, byte1_d;
    logic              pkt_valid_q, pkt_valid_d;
    logic              sync_err_q, sync_err_d;
    logic [2:0]        btn_q, btn_d;
    logic [8:0]        dx_q, dx_d;
    logic [8:0]        dy_q, dy_d;
    logic              x_ovf_q, x_ovf_d;
    logic              y_ovf_q, y_ovf_d;
    logic [POS_W-1:0]  pos_x_q, pos_x_d;
    logic [POS_W-1:0]  pos_y_q, pos_y_d;

    logic [8:0]            dx_new, dy_new;
    logic signed [PW-1:0]  dx_ext, dy_ext, nx, ny;
    logic [POS_W-1:0]      nx_clamp, ny_clamp;

    // Candidate packet fields, valid only while byte2 is being accepted.
    always_comb begin
        dx_new = {byte0_q[4], byte1_q};
        dy_new = {byte0_q[5], rx_data};
        dx_ext = byte0_q[6] ? '0 : {{(PW-9){dx_new[8]}}, dx_new};
        dy_ext = byte0_q[7] ? '0 : {{(PW-9){dy_new[8]}}, dy_new};
        nx     = $signed({2'b00, pos_x_q}) + dx_ext;
        ny     = $signed({2'b00, pos_y_q}) - dy_ext;
        if (nx[PW-1])
            nx_clamp = '0;
        else if (nx > X_MAX_S)
            nx_clamp = X_MAX_S[POS_W-1:0];
        else
            nx_clamp = nx[POS_W-1:0];
        if (ny[PW-1])
            ny_clamp = '0;
        else if (ny > Y_MAX_S)
            ny_clamp = Y_MAX_S[POS_W-1:0];
        else
            ny_clamp = ny[POS_W-1:0];
    end

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        byte0_d     = byte0_q;
        byte1_d     = byte1_q;
        pkt_valid_d = 1'b0;
        sync_err_d  = 1'b0;
        btn_d       = btn_q;
        dx_d        = dx_q;
        dy_d        = dy_q;
        x_ovf_d     = x_ovf_q;
        y_ovf_d     = y_ovf_q;
        pos_x_d     = pos_x_q;
        pos_y_d     = pos_y_q;
        if (!stream_en) begin
            state_d = S_B0;
            timer_d = '0;
        end else begin
            case (state_q)
                S_B0: begin
                    timer_d = '0;
                    if (rx_done) begin
                        if (rx_data[3]) begin
                            byte0_d = rx_data;
                            state_d = S_B1;
                        end else begin
                            sync_err_d = 1'b1;
                        end
                    end
                end
                S_B1, S_B2: begin
                    // An arriving byte beats a timeout expiring in the same cycle.
                    if (rx_done) begin
                        timer_d = '0;
                        if (state_q == S_B1) begin
                            byte1_d = rx_data;
                            state_d = S_B2;
                        end else begin
                            state_d     = S_B0;
                            pkt_valid_d = 1'b1;
                            btn_d       = byte0_q[2:0];
                            dx_d        = dx_new;
                            dy_d        = dy_new;
                            x_ovf_d     = byte0_q[6];
                            y_ovf_d     = byte0_q[7];
                            pos_x_d     = nx_clamp;
                            pos_y_d     = ny_clamp;
                        end
                    end else if (timer_q == T_LAST) begin
                        state_d    = S_B0;
                        timer_d    = '0;
                        sync_err_d = 1'b1;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
                default: begin
                    state_d = S_B0;
                    timer_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q     <= S_B0;
            timer_q     <= '0;
            byte0_q     <= '0;
            byte1_q     <= '0;
            pkt_valid_q <= 1'b0;
            sync_err_q  <= 1'b0;
            btn_q       <= '0;
            dx_q        <= '0;
            dy_q        <= '0;
            x_ovf_q     <= 1'b0;
            y_ovf_q     <= 1'b0;
            pos_x_q     <= X_CTR;
            pos_y_q     <= Y_CTR;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            byte0_q     <= byte0_d;
            byte1_q     <= byte1_d;
            pkt_valid_q <= pkt_valid_d;
            sync_err_q  <= sync_err_d;
            btn_q       <= btn_d;
            dx_q        <= dx_d;
            dy_q        <= dy_d;
            x_ovf_q     <= x_ovf_d;
            y_ovf_q     <= y_ovf_d;
            pos_x_q     <= pos_x_d;
            pos_y_q     <= pos_y_d;
        end
    end

    assign pkt_valid = pkt_valid_q;
    assign sync_err  = sync_err_q;
    assign btn_l     = btn_q[0];
    assign btn_r     = btn_q[1];
    assign btn_m     = btn_q[2];
    assign dx        = dx_q;
    assign dy        = dy_q;
    assign x_ovf     = x_ovf_q;
    assign y_ovf     = y_ovf_q;
    assign pos_x     = pos_x_q;
    assign pos_y     = pos_y_q;
    assign busy      = (state_q != S_B0);

endmodule

// File: tb/tb_ps2_mouse_packet_assembler.sv
// tb/tb_ps2_mouse_packet_assembler.sv - directed scoreboard bench for the PS/2 packet assembler
module tb_ps2_mouse_packet_assembler;

    localparam int TMO = 64;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_done = 1'b0;
    logic       stream_en = 1'b0;
    logic       pkt_valid, btn_l, btn_r, btn_m, x_ovf, y_ovf, sync_err, busy;
    logic [8:0] dx, dy;
    logic [9:0] pos_x, pos_y;

    ps2_mouse_packet_assembler #(
        .TIMEOUT_CYCLES(TMO), .POS_W(10), .X_MAX(639), .Y_MAX(479)
    ) dut (
        .CLK(CLK), .RST(RST), .rx_data(rx_data), .rx_done(rx_done), .stream_en(stream_en),
        .pkt_valid(pkt_valid), .btn_l(btn_l), .btn_r(btn_r), .btn_m(btn_m),
        .dx(dx), .dy(dy), .x_ovf(x_ovf), .y_ovf(y_ovf),
        .pos_x(pos_x), .pos_y(pos_y), .sync_err(sync_err), .busy(busy)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [2:0] btn;
        logic [8:0] dx;
        logic [8:0] dy;
        logic       xo;
        logic       yo;
        logic [9:0] px;
        logic [9:0] py;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   n_pkt = 0;
    int   n_err = 0;
    int   mx = 320;
    int   my = 240;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    always @(negedge CLK) begin
        if (pkt_valid) n_pkt++;
        if (sync_err) n_err++;
        if (pkt_valid || sync_err) chk("strobe_exclusive", {31'd0, pkt_valid & sync_err}, 32'd0);
    end

    function automatic int clampi(input int v, input int hi);
        return (v < 0) ? 0 : ((v > hi) ? hi : v);
    endfunction

    task automatic push_pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        exp_t e;
        int   dxi, dyi;
        dxi = b0[4] ? int'(b1) - 256 : int'(b1);
        dyi = b0[5] ? int'(b2) - 256 : int'(b2);
        if (!b0[6]) mx = clampi(mx + dxi, 639);
        if (!b0[7]) my = clampi(my - dyi, 479);
        e.btn = b0[2:0];
        e.dx  = {b0[4], b1};
        e.dy  = {b0[5], b2};
        e.xo  = b0[6];
        e.yo  = b0[7];
        e.px  = 10'(mx);
        e.py  = 10'(my);
        exp_q.push_back(e);
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge CLK);
        rx_data = b;
        rx_done = 1'b1;
        @(negedge CLK);
        rx_done = 1'b0;
    endtask

    task automatic wait_pkt(input string tag);
        exp_t e;
        int   n = 0;
        while (!pkt_valid && n < 20) begin
            @(negedge CLK);
            n++;
        end
        chk({tag, "_pkt_valid"}, {31'd0, pkt_valid}, 32'd1);
        if (pkt_valid && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk({tag, "_btn"}, {29'd0, btn_m, btn_r, btn_l}, {29'd0, e.btn});
            chk({tag, "_dx"}, {23'd0, dx}, {23'd0, e.dx});
            chk({tag, "_dy"}, {23'd0, dy}, {23'd0, e.dy});
            chk({tag, "_ovf"}, {30'd0, y_ovf, x_ovf}, {30'd0, e.yo, e.xo});
            chk({tag, "_pos_x"}, {22'd0, pos_x}, {22'd0, e.px});
            chk({tag, "_pos_y"}, {22'd0, pos_y}, {22'd0, e.py});
        end
    endtask

    task automatic do_packet(input string tag, input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        push_pkt(b0, b1, b2);
        send_byte(b0);
        send_byte(b1);
        send_byte(b2);
        wait_pkt(tag);
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        RST = 1'b1;
        mx = 320;
        my = 240;
        exp_q.delete();
    endtask

    initial begin
        int p0, e0, n;
        stream_en = 1'b1;
        @(negedge CLK);
        chk("reset_pos_x", {22'd0, pos_x}, 32'd320);
        chk("reset_pos_y", {22'd0, pos_y}, 32'd240);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_strobes", {30'd0, pkt_valid, sync_err}, 32'd0);
        chk("reset_fields", {5'd0, btn_l, btn_r, btn_m, dx, dy, x_ovf, y_ovf}, 32'd0);
        RST = 1'b1;

        // basic packet, also checked against literal expectations
        do_packet("t1", 8'h29, 8'h05, 8'hFE);
        chk("t1_pos_x_lit", {22'd0, pos_x}, 32'd325);
        chk("t1_pos_y_lit", {22'd0, pos_y}, 32'd242);
        @(negedge CLK);
        chk("t1_pkt_one_cycle", {31'd0, pkt_valid}, 32'd0);
        chk("t1_hold_dx", {23'd0, dx}, 32'd5);

        // bad header then good packet
        do_reset();
        send_byte(8'h00);
        chk("t2_sync_err", {31'd0, sync_err}, 32'd1);
        chk("t2_busy_after_bad", {31'd0, busy}, 32'd0);
        do_packet("t2", 8'h08, 8'h01, 8'h01);
        chk("t2_pos_y_lit", {22'd0, pos_y}, 32'd239);

        // -256 deltas and left clamp
        do_reset();
        do_packet("t3a", 8'h18, 8'h00, 8'h00);
        chk("t3a_pos_x_lit", {22'd0, pos_x}, 32'd64);
        do_packet("t3b", 8'h18, 8'h00, 8'h00);
        chk("t3b_pos_x_lit", {22'd0, pos_x}, 32'd0);

        // clamps at the far edges
        do_packet("t3c", 8'h08, 8'hFF, 8'h00);
        do_packet("t3d", 8'h08, 8'hFF, 8'h00);
        do_packet("t3e", 8'h08, 8'hFF, 8'h00);
        chk("t3e_pos_x_max", {22'd0, pos_x}, 32'd639);
        do_packet("t3f", 8'h28, 8'h00, 8'h00);
        do_packet("t3g", 8'h28, 8'h00, 8'h00);
        chk("t3g_pos_y_max", {22'd0, pos_y}, 32'd479);

        // X overflow suppresses X motion
        do_reset();
        do_packet("t4", 8'h48, 8'h7F, 8'h00);
        chk("t4_pos_x_lit", {22'd0, pos_x}, 32'd320);

        // inter-byte timeout
        do_reset();
        p0 = n_pkt;
        e0 = n_err;
        send_byte(8'h08);
        send_byte(8'h01);
        chk("t5_busy_mid", {31'd0, busy}, 32'd1);
        n = 0;
        while (!sync_err && n < TMO + 10) begin
            @(negedge CLK);
            n++;
        end
        chk("t5_timeout_err", {31'd0, sync_err}, 32'd1);
        chk("t5_busy_after", {31'd0, busy}, 32'd0);
        repeat (4) @(negedge CLK);
        chk("t5_no_pkt", n_pkt, p0);
        chk("t5_one_err", n_err, e0 + 1);
        do_packet("t5", 8'h09, 8'h02, 8'h00);

        // stream_en low aborts silently
        e0 = n_err;
        send_byte(8'h08);
        @(negedge CLK);
        stream_en = 1'b0;
        @(negedge CLK);
        chk("se_busy", {31'd0, busy}, 32'd0);
        send_byte(8'h08);
        chk("se_ignored", {31'd0, busy}, 32'd0);
        stream_en = 1'b1;
        chk("se_no_err", n_err, e0);
        send_byte(8'h01);
        chk("se_hdr_reject", {31'd0, sync_err}, 32'd1);

        // reset mid-packet
        do_packet("t6pre", 8'h08, 8'h05, 8'h05);
        send_byte(8'h08);
        send_byte(8'h01);
        @(negedge CLK);
        RST = 1'b0;
        #1;
        chk("t6_rst_busy", {31'd0, busy}, 32'd0);
        chk("t6_rst_pos", {12'd0, pos_x, pos_y}, {12'd0, 10'd320, 10'd240});
        @(negedge CLK);
        RST = 1'b1;
        send_byte(8'h01);
        chk("t6_sync_err", {31'd0, sync_err}, 32'd1);
        chk("t6_pos_x", {22'd0, pos_x}, 32'd320);
        chk("t6_pos_y", {22'd0, pos_y}, 32'd240);

        repeat (3) @(negedge CLK);
        chk("queue_drained", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
